afifo_rd_pack: RTL and testbench

//  Read-side consumer of the async FIFO, in the rd_clk domain. Pops BITWID-bit words from the FIFO
//  and packs PACK consecutive words little-endian into one output word on a valid/ready stream.

---
 rtl/afifo_rd_pack.sv | 132 +++++++++++++
 tb/tb_afifo_rd_pack.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_pack.sv
// Read-side consumer of the async FIFO: pops words using the registered occupancy,
// packs PACK words little-endian into one output word on a valid/ready stream, and
// emits a partial word with a lane-keep mask on flush.
module afifo_rd_pack #(
    parameter int unsigned DEEPWID = 3,
    parameter int unsigned BITWID  = 8,
    parameter int unsigned PACK    = 4,
    parameter int unsigned PACKWID = 2
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    input  logic [DEEPWID:0]         fifo_rd_num,
    output logic                     fifo_rd,
    input  logic [BITWID-1:0]        fifo_rd_dat,
    input  logic                     fifo_rd_dat_vld,
    input  logic                     flush,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [BITWID*PACK-1:0]   out_dat,
    output logic [PACK-1:0]          out_keep,
    output logic                     busy
);

    localparam logic [PACKWID-1:0] LAST_LANE = PACKWID'(PACK - 1);

    typedef enum logic [0:0] {StFill, StFlush} state_e;

    state_e                   state;
    logic [PACKWID-1:0]       iss_idx;
    logic [PACKWID-1:0]       rcv_idx;
    logic                     inflight;
    logic [BITWID*PACK-1:0]   acc;

    logic                     flush_pend;
    logic                     last_lane;
    logic                     slot_free;
    logic                     capture;
    logic                     final_cap;
    logic                     flush_idle;
    logic                     flush_load;
    logic [BITWID*PACK-1:0]   acc_cap;
    logic [PACK-1:0]          keep_part;

    assign flush_pend = (state == StFlush);
    assign last_lane  = (iss_idx == LAST_LANE);
    assign slot_free  = !out_vld || out_rdy;
    // The final lane may only be popped if the output slot is free when its data lands.
    assign fifo_rd    = !rd_rst && (fifo_rd_num != '0) && !flush_pend && (!last_lane || slot_free);
    // Data with no read outstanding (e.g. issued before a reset) is dropped.
    assign capture    = fifo_rd_dat_vld && inflight;
    assign final_cap  = capture && (rcv_idx == LAST_LANE);
    assign flush_idle = flush_pend && !inflight && (rcv_idx == '0);
    assign flush_load = flush_pend && !inflight && (rcv_idx != '0) && slot_free;
    assign busy       = (rcv_idx != '0) || inflight || flush_pend || out_vld;

    // Accumulator with the arriving word merged in, and the partial keep mask.
    always_comb begin
        acc_cap = acc;
        if (capture) begin
            acc_cap[int'(rcv_idx)*BITWID +: BITWID] = fifo_rd_dat;
        end
        keep_part = '0;
        for (int k = 0; k < int'(PACK); k++) begin
            keep_part[k] = (k < int'(rcv_idx));
        end
    end

    // Issue/receive counters, accumulator, output register and FILL/FLUSH control.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state    <= StFill;
            iss_idx  <= '0;
            rcv_idx  <= '0;
            inflight <= 1'b0;
            acc      <= '0;
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_keep <= '0;
        end else begin
            inflight <= fifo_rd || (inflight && !fifo_rd_dat_vld);

            if (fifo_rd) begin
                iss_idx <= last_lane ? '0 : iss_idx + 1'b1;
            end

            if (capture) begin
                if (final_cap) begin
                    rcv_idx <= '0;
                    acc     <= '0;
                end else begin
                    rcv_idx <= rcv_idx + 1'b1;
                    acc     <= acc_cap;
                end
            end

            // Loading a new word in the same edge as a drain keeps out_vld high.
            if (final_cap) begin
                out_dat  <= acc_cap;
                out_keep <= '1;
                out_vld  <= 1'b1;
            end else if (flush_load) begin
                out_dat  <= acc;
                out_keep <= keep_part;
                out_vld  <= 1'b1;
            end else if (out_rdy) begin
                out_vld  <= 1'b0;
            end

            unique case (state)
                StFill: begin
                    if (flush) begin
                        state <= StFlush;
                    end
                end
                StFlush: begin
                    // A flush seen here is absorbed into the one already pending.
                    if (flush_idle) begin
                        iss_idx <= '0;
                        state   <= StFill;
                    end else if (flush_load) begin
                        iss_idx <= '0;
                        rcv_idx <= '0;
                        acc     <= '0;
                        state   <= StFill;
                    end
                end
                default: state <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_rd_pack.sv
// Scoreboard bench for afifo_rd_pack: a queue-based FIFO source, a byte-list packing
// model feeding an expected-word queue, and an independent output monitor.
module tb_afifo_rd_pack;

    localparam int unsigned DW = 3;
    localparam int unsigned BW = 8;
    localparam int unsigned PK = 4;
    localparam int unsigned PW = 2;

    logic             rd_clk = 1'b0;
    logic             rd_rst;
    logic [DW:0]      fifo_rd_num;
    logic             fifo_rd;
    logic [BW-1:0]    fifo_rd_dat;
    logic             fifo_rd_dat_vld;
    logic             flush;
    logic             out_vld;
    logic             out_rdy;
    logic [BW*PK-1:0] out_dat;
    logic [PK-1:0]    out_keep;
    logic             busy;

    afifo_rd_pack #(.DEEPWID(DW), .BITWID(BW), .PACK(PK), .PACKWID(PW)) dut (
        .rd_clk          (rd_clk),
        .rd_rst          (rd_rst),
        .fifo_rd_num     (fifo_rd_num),
        .fifo_rd         (fifo_rd),
        .fifo_rd_dat     (fifo_rd_dat),
        .fifo_rd_dat_vld (fifo_rd_dat_vld),
        .flush           (flush),
        .out_vld         (out_vld),
        .out_rdy         (out_rdy),
        .out_dat         (out_dat),
        .out_keep        (out_keep),
        .busy            (busy)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  keep;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] src_q[$];
    logic [7:0] mdl_q[$];
    int         errors = 0;
    int         checks = 0;
    int         pops = 0;
    logic       pend_vld = 1'b0;
    logic [7:0] pend_dat = 8'h00;
    logic       rst_release = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: popped bytes collect in order; a full set or a flush makes one word.
    task automatic mdl_emit();
        word_t w;
        w.dat  = '0;
        w.keep = '0;
        foreach (mdl_q[k]) begin
            w.dat[k*8 +: 8] = mdl_q[k];
            w.keep[k]       = 1'b1;
        end
        if (mdl_q.size() > 0) exp_q.push_back(w);
        mdl_q.delete();
    endtask

    task automatic mdl_push(input logic [7:0] b);
        mdl_q.push_back(b);
        if (mdl_q.size() == PK) mdl_emit();
    endtask

    // One cycle: drive inputs at negedge, sample the pop strobe just after.
    task automatic tick(input logic rdy, input logic fl);
        @(negedge rd_clk);
        if (rst_release) begin
            rd_rst      = 1'b0;
            rst_release = 1'b0;
        end
        fifo_rd_dat_vld = pend_vld;
        fifo_rd_dat     = pend_dat;
        fifo_rd_num     = (src_q.size() > 8) ? 4'd8 : 4'(src_q.size());
        out_rdy         = rdy;
        flush           = fl;
        #2;
        pend_vld = 1'b0;
        if (fifo_rd) begin
            chk("pop_nonempty", 64'(fifo_rd_num != 0), 1);
            if (src_q.size() > 0) begin
                pend_dat = src_q.pop_front();
                pend_vld = 1'b1;
                pops++;
                mdl_push(pend_dat);
            end
        end
        if (fl) mdl_emit();
    endtask

    // Monitor: compares every accepted word and checks stability under backpressure.
    logic        hold = 1'b0;
    logic [31:0] hdat;
    logic [3:0]  hkeep;
    word_t       mon_w;
    always @(negedge rd_clk) begin
        #3;
        if (rd_rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_vld", 64'(out_vld), 1);
                chk("hold_dat", 64'(out_dat), 64'(hdat));
                chk("hold_keep", 64'(out_keep), 64'(hkeep));
            end
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_word: got unexpected %h keep %b, required none", out_dat,
                             out_keep);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("out_dat", 64'(out_dat), 64'(mon_w.dat));
                    chk("out_keep", 64'(out_keep), 64'(mon_w.keep));
                end
            end
            hold  = out_vld && !out_rdy;
            hdat  = out_dat;
            hkeep = out_keep;
        end
    end

    initial begin
        rd_rst          = 1'b1;
        fifo_rd_num     = 4'd5;
        fifo_rd_dat     = '0;
        fifo_rd_dat_vld = 1'b0;
        flush           = 1'b0;
        out_rdy         = 1'b0;
        #12;
        chk("rst_fifo_rd", 64'(fifo_rd), 0);
        chk("rst_out_vld", 64'(out_vld), 0);
        chk("rst_out_dat", 64'(out_dat), 0);
        chk("rst_out_keep", 64'(out_keep), 0);
        chk("rst_busy", 64'(busy), 0);
        @(negedge rd_clk);
        rd_rst      = 1'b0;
        fifo_rd_num = '0;

        // Streaming at full rate.
        pops  = 0;
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        repeat (5) tick(1'b1, 1'b0);
        chk("lat_before", 64'(out_vld), 0);
        tick(1'b1, 1'b0);
        chk("lat_at", 64'(out_vld), 1);
        chk("lat_dat", 64'(out_dat), 64'h44332211);
        repeat (2) tick(1'b1, 1'b0);
        chk("stream_pops", 64'(pops), 8);
        repeat (6) tick(1'b1, 1'b0);

        // Backpressure withholds the final pop of the second word.
        pops  = 0;
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        repeat (12) tick(1'b0, 1'b0);
        chk("bp_pops", 64'(pops), 7);
        chk("bp_fifo_rd", 64'(fifo_rd), 0);
        chk("bp_vld", 64'(out_vld), 1);
        chk("bp_dat", 64'(out_dat), 64'h44332211);
        repeat (10) tick(1'b1, 1'b0);
        chk("bp_pops_all", 64'(pops), 8);

        // Starvation then one more byte.
        pops  = 0;
        src_q = '{8'h01, 8'h02, 8'h03};
        repeat (8) tick(1'b1, 1'b0);
        chk("starve_pops", 64'(pops), 3);
        chk("starve_vld", 64'(out_vld), 0);
        chk("starve_busy", 64'(busy), 1);
        src_q.push_back(8'h04);
        repeat (6) tick(1'b1, 1'b0);

        // Partial flush, then a flush with nothing accumulated.
        src_q = '{8'hA1, 8'hB2};
        repeat (4) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (2) tick(1'b1, 1'b0);
        chk("flush_dat", 64'(out_dat), 64'h0000B2A1);
        chk("flush_keep", 64'(out_keep), 64'h3);
        repeat (3) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (4) tick(1'b1, 1'b0);
        chk("empty_flush_vld", 64'(out_vld), 0);
        chk("empty_flush_busy", 64'(busy), 0);

        // Flush (twice) while a full word is stalled and one byte is held.
        src_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        repeat (9) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0);
        chk("stall_flush_keep", 64'(out_keep), 64'hF);
        chk("stall_flush_dat", 64'(out_dat), 64'hC4C3C2C1);
        repeat (6) tick(1'b1, 1'b0);

        // Randomized traffic, backpressure and flushes.
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 6)) src_q.push_back(8'($urandom));
            end
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
        end
        repeat (40) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (6) tick(1'b1, 1'b0);
        chk("drain_exp_empty", 64'(exp_q.size()), 0);
        chk("drain_busy", 64'(busy), 0);

        // Reset mid-word with a read outstanding; its data must be ignored.
        src_q = '{8'hD1, 8'hD2, 8'hD3};
        repeat (3) tick(1'b1, 1'b0);
        @(posedge rd_clk);
        #1;
        rd_rst = 1'b1;
        #1;
        chk("mid_rst_fifo_rd", 64'(fifo_rd), 0);
        chk("mid_rst_vld", 64'(out_vld), 0);
        chk("mid_rst_keep", 64'(out_keep), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        mdl_q.delete();
        rst_release = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("post_rst_busy", 64'(busy), 0);
        chk("post_rst_vld", 64'(out_vld), 0);
        src_q = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        repeat (8) tick(1'b1, 1'b0);
        chk("final_exp_empty", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
